// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if
//   Groups the parser's byte input, command handshake and status signals.
//   master: the parser side (consumes rx bytes, drives command and status).
//   slave : the UART receiver / register block / monitor side.
// Signals:
//   rx_data/rx_done             byte stream from the UART receiver
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/cmd_addr/cmd_wdata decoded command fields
//   err/ovr/busy                status pulses and line-in-progress flag
interface uart_cmd_parser_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              err;
  logic              ovr;
  logic              busy;

  modport master (
    input  rx_data, rx_done, cmd_ready,
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, err, ovr, busy
  );

  modport slave (
    output rx_data, rx_done, cmd_ready,
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, err, ovr, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Turns ASCII hex command lines from a UART receiver into register-bus
//   commands. "W<addr><data><CR|LF>" is a write, "R<addr><CR|LF>" a read.
//   Malformed or timed-out lines are dropped with an err pulse; bytes that
//   arrive while a command is still pending are dropped with an ovr pulse.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  uart_cmd_parser_if.master (rx byte in, command out, status out)
module uart_cmd_parser #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_parser_if.master     bus
);

  localparam int ADDR_DIG = ADDR_W / 4;
  localparam int DATA_DIG = DATA_W / 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOL     = 3'd3,
    ST_DISCARD = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters share a low nibble of 1..6 in both cases, so A/a map to 1+9.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) begin
      return b[3:0];
    end else begin
      return b[3:0] + 4'd9;
    end
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  state_t            state_r, state_s;
  logic              write_r, write_s;
  logic [ADDR_W-1:0] addr_sh_r, addr_sh_s;
  logic [DATA_W-1:0] data_sh_r, data_sh_s;
  logic [7:0]        dig_r, dig_s;
  logic [31:0]       tmo_r, tmo_s;
  logic              cmd_valid_r, cmd_write_r, err_r, ovr_r, busy_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [DATA_W-1:0] cmd_wdata_r;
  logic              err_s, ovr_s, load_s, in_line_s, tmo_hit_s;

  // Next-state, shift-register, timeout and pulse logic.
  always_comb begin
    state_s   = state_r;
    write_s   = write_r;
    addr_sh_s = addr_sh_r;
    data_sh_s = data_sh_r;
    dig_s     = dig_r;
    err_s     = 1'b0;
    ovr_s     = 1'b0;
    load_s    = 1'b0;
    in_line_s = (state_r == ST_ADDR) || (state_r == ST_DATA) ||
                (state_r == ST_EOL)  || (state_r == ST_DISCARD);

    if (in_line_s && !bus.rx_done) begin
      tmo_s = tmo_r + 32'd1;
    end else begin
      tmo_s = 32'd0;
    end
    // A byte in the expiry cycle wins because tmo_hit_s requires !rx_done.
    tmo_hit_s = (TIMEOUT_CYC != 0) && in_line_s && !bus.rx_done &&
                (tmo_r == 32'(TIMEOUT_CYC - 1));

    case (state_r)
      ST_IDLE: begin
        if (bus.rx_done) begin
          if ((bus.rx_data == 8'h57) || (bus.rx_data == 8'h77) ||
              (bus.rx_data == 8'h52) || (bus.rx_data == 8'h72)) begin
            state_s   = ST_ADDR;
            write_s   = (bus.rx_data == 8'h57) || (bus.rx_data == 8'h77);
            addr_sh_s = '0;
            data_sh_s = '0;
            dig_s     = 8'd0;
          end else if (is_term(bus.rx_data)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DISCARD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus.rx_done) begin
          if (is_hex(bus.rx_data)) begin
            addr_sh_s = ADDR_W'({addr_sh_r, hex_val(bus.rx_data)});
            if (dig_r == 8'(ADDR_DIG - 1)) begin
              dig_s   = 8'd0;
              state_s = write_r ? ST_DATA : ST_EOL;
            end else begin
              dig_s = dig_r + 8'd1;
            end
          end else if (is_term(bus.rx_data)) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DISCARD;
          end
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (bus.rx_done) begin
          if (is_hex(bus.rx_data)) begin
            data_sh_s = DATA_W'({data_sh_r, hex_val(bus.rx_data)});
            if (dig_r == 8'(DATA_DIG - 1)) begin
              dig_s   = 8'd0;
              state_s = ST_EOL;
            end else begin
              dig_s = dig_r + 8'd1;
            end
          end else if (is_term(bus.rx_data)) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DISCARD;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_EOL: begin
        if (bus.rx_done) begin
          if (is_term(bus.rx_data)) begin
            state_s = ST_HOLD;
            load_s  = 1'b1;
          end else begin
            state_s = ST_DISCARD;
          end
        end else begin
          state_s = ST_EOL;
        end
      end
      ST_DISCARD: begin
        if (bus.rx_done && is_term(bus.rx_data)) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DISCARD;
        end
      end
      ST_HOLD: begin
        ovr_s = bus.rx_done;
        if (cmd_valid_r && bus.cmd_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (tmo_hit_s) begin
      err_s   = 1'b1;
      state_s = ST_IDLE;
      tmo_s   = 32'd0;
    end else begin
      tmo_s = tmo_s;
    end
  end

  // State, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      write_r     <= 1'b0;
      addr_sh_r   <= '0;
      data_sh_r   <= '0;
      dig_r       <= 8'd0;
      tmo_r       <= 32'd0;
      cmd_valid_r <= 1'b0;
      cmd_write_r <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_wdata_r <= '0;
      err_r       <= 1'b0;
      ovr_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      write_r     <= write_s;
      addr_sh_r   <= addr_sh_s;
      data_sh_r   <= data_sh_s;
      dig_r       <= dig_s;
      tmo_r       <= tmo_s;
      cmd_valid_r <= (state_s == ST_HOLD);
      err_r       <= err_s;
      ovr_r       <= ovr_s;
      busy_r      <= (state_s == ST_ADDR) || (state_s == ST_DATA) ||
                     (state_s == ST_EOL)  || (state_s == ST_DISCARD);
      // Fields only change on entry to HOLD; reads keep the old wdata.
      if (load_s) begin
        cmd_write_r <= write_r;
        cmd_addr_r  <= addr_sh_r;
        if (write_r) begin
          cmd_wdata_r <= data_sh_r;
        end
      end
    end
  end

  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_write = cmd_write_r;
  assign bus.cmd_addr  = cmd_addr_r;
  assign bus.cmd_wdata = cmd_wdata_r;
  assign bus.err       = err_r;
  assign bus.ovr       = ovr_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;
  int   ovr_cnt = 0;
  int   val_cnt = 0;

  always #5 clk = ~clk;

  uart_cmd_parser_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  uart_cmd_parser #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Count cycles in which each status signal was high.
  always @(posedge clk) begin
    if (bus.err) err_cnt <= err_cnt + 1;
    if (bus.ovr) ovr_cnt <= ovr_cnt + 1;
    if (bus.cmd_valid) val_cnt <= val_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    bus.cmd_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    bus.rx_data = 8'h00; bus.rx_done = 1'b0; bus.cmd_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    got = {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.err, bus.ovr, bus.busy};
    checks++;
    if (got !== 21'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 21'd0);
    end
  endtask

  task automatic test_write();
    logic [17:0] got;
    send_str("W1A5C");
    @(posedge clk); #1;
    bus.rx_data = 8'h0D; bus.rx_done = 1'b1;
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      failures++; $display("FAIL wr_valid_early got=%b exp=0", bus.cmd_valid);
    end
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    got = {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    checks++;
    if (got !== {1'b1, 1'b1, 8'h1A, 8'h5C}) begin
      failures++; $display("FAIL wr_cmd got=%h exp=%h", got, {1'b1, 1'b1, 8'h1A, 8'h5C});
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      got = {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
      checks++;
      if (got !== {1'b1, 1'b1, 8'h1A, 8'h5C}) begin
        failures++; $display("FAIL wr_hold_stable cyc=%0d got=%h exp=%h", i, got, {1'b1, 1'b1, 8'h1A, 8'h5C});
      end
    end
    handshake();
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      failures++; $display("FAIL wr_valid_after_ready got=%b exp=0", bus.cmd_valid);
    end
  endtask

  task automatic test_read();
    logic [17:0] got;
    int e0;
    e0 = err_cnt;
    send_str("\nr7f\r");
    got = {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    checks++;
    if (got !== {1'b1, 1'b0, 8'h7F, 8'h5C}) begin
      failures++; $display("FAIL rd_cmd got=%h exp=%h", got, {1'b1, 1'b0, 8'h7F, 8'h5C});
    end
    handshake();
    send_byte(8'h0A);
    repeat (2) @(posedge clk); #1;
    checks++;
    if ((err_cnt - e0) !== 0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL rd_lf_ignored errs=%0d busy=%b exp errs=0 busy=0", err_cnt - e0, bus.busy);
    end
  endtask

  task automatic test_malformed();
    int e0, v0;
    string lines[3];
    lines[0] = "W1G55\r"; lines[1] = "W12\r"; lines[2] = "R123\r";
    for (int k = 0; k < 3; k++) begin
      e0 = err_cnt; v0 = val_cnt;
      send_str(lines[k]);
      checks++;
      if (bus.err !== 1'b1 || bus.cmd_valid !== 1'b0) begin
        failures++; $display("FAIL bad_line%0d_err got err=%b valid=%b exp err=1 valid=0", k, bus.err, bus.cmd_valid);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if ((err_cnt - e0) !== 1 || (val_cnt - v0) !== 0) begin
        failures++; $display("FAIL bad_line%0d_count got errs=%0d valids=%0d exp errs=1 valids=0", k, err_cnt - e0, val_cnt - v0);
      end
    end
  endtask

  task automatic test_overrun();
    send_str("R33\r");
    send_byte(8'h52);
    checks++;
    if (bus.ovr !== 1'b1 || bus.cmd_addr !== 8'h33 || bus.cmd_valid !== 1'b1) begin
      failures++; $display("FAIL ovr_pulse got ovr=%b addr=%h valid=%b exp ovr=1 addr=33 valid=1", bus.ovr, bus.cmd_addr, bus.cmd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ovr !== 1'b0) begin
      failures++; $display("FAIL ovr_one_cycle got=%b exp=0", bus.ovr);
    end
    handshake();
    send_str("R05\r");
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== 8'h05 || bus.cmd_write !== 1'b0) begin
      failures++; $display("FAIL ovr_next_cmd got valid=%b addr=%h wr=%b exp 1 05 0", bus.cmd_valid, bus.cmd_addr, bus.cmd_write);
    end
    // Byte and ready in the same cycle: drop, ovr, handshake completes.
    @(posedge clk); #1;
    bus.rx_data = 8'h58; bus.rx_done = 1'b1; bus.cmd_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0; bus.cmd_ready = 1'b0;
    checks++;
    if (bus.ovr !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL ovr_with_ready got ovr=%b valid=%b busy=%b exp 1 0 0", bus.ovr, bus.cmd_valid, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_str("W1");
    repeat (49) @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL tmo_early got err=%b busy=%b exp err=0 busy=1", bus.err, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL tmo_fire got err=%b busy=%b exp err=1 busy=0", bus.err, bus.busy);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ((err_cnt - e0) !== 1) begin
      failures++; $display("FAIL tmo_once got=%0d exp=1", err_cnt - e0);
    end
    send_str("R10\r");
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== 8'h10 || bus.cmd_write !== 1'b0) begin
      failures++; $display("FAIL tmo_recover got valid=%b addr=%h wr=%b exp 1 10 0", bus.cmd_valid, bus.cmd_addr, bus.cmd_write);
    end
    handshake();
  endtask

  task automatic test_midline_reset();
    logic [20:0] got;
    int v0;
    send_str("W12");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    got = {bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.err, bus.ovr, bus.busy};
    checks++;
    if (got !== 21'd0) begin
      failures++; $display("FAIL rst_midline got=%h exp=%h", got, 21'd0);
    end
    v0 = val_cnt;
    send_str("34\r");
    checks++;
    if (bus.err !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      failures++; $display("FAIL rst_after_err got err=%b valid=%b exp err=1 valid=0", bus.err, bus.cmd_valid);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if ((val_cnt - v0) !== 0) begin
      failures++; $display("FAIL rst_no_cmd got=%0d exp=0", val_cnt - v0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_malformed();
    test_overrun();
    test_timeout();
    test_midline_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (rx_data qualified by the one-cycle rx_done pulse).
- Parses ASCII hex command lines into register-bus transactions.
- Write line: 'W'/'w', ADDR_W/4 hex address digits, DATA_W/4 hex data digits, then CR or LF.
- Read line: 'R'/'r', address digits, then CR or LF.
- Each decoded command is presented on a valid/ready interface to the register block.

Parameters:
ADDR_W, 8, address width in bits; must be a multiple of 4; one hex digit per nibble.
DATA_W, 8, write-data width in bits; must be a multiple of 4.
TIMEOUT_CYC, 100_000_000, clocks without a byte before a partial line is aborted; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  received byte; valid only in a cycle where rx_done=1
rx_done  input  1  one-cycle pulse, byte available
cmd_valid  output  1  decoded command available
cmd_ready  input  1  consumer accepts the command
cmd_write  output  1  1=write, 0=read
cmd_addr  output  ADDR_W  command address
cmd_wdata  output  DATA_W  write data; holds its previous value on reads
err  output  1  one-cycle pulse, malformed or timed-out line dropped
ovr  output  1  one-cycle pulse, byte dropped while a command was pending
busy  output  1  a line is partially received

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: cmd_valid, cmd_write, err, ovr and busy are 0; cmd_addr and cmd_wdata are 0.
- A byte is consumed on the rising edge where rx_done=1. Bytes with rx_done=0 are ignored.
- Hex digits are 0-9, A-F and a-f. Terminators are 0x0D and 0x0A.
- Nibble entry shifts left: shift = {shift[W-5:0], nibble}, so the first digit is most significant.
- Internal shift registers are loaded into cmd_* only on entry to HOLD. cmd_* are therefore stable for the whole time cmd_valid=1.
- State machine (the rule for each state follows; busy=1 in ADDR, DATA, EOL and DISCARD):
  - IDLE:
    - 'W'/'w' → ADDR, with write flag set and shift registers cleared.
    - 'R'/'r' → ADDR, with write flag clear and shift registers cleared.
    - A terminator is ignored and the FSM stays in IDLE, so CRLF pairs are harmless.
    - Any other byte → DISCARD.
  - ADDR:
    - Hex digit: shift it in. After ADDR_W/4 digits, go to DATA if a write, else to EOL.
    - Terminator: err pulse → IDLE.
    - Other byte → DISCARD.
  - DATA: same as ADDR, with DATA_W/4 digits → EOL.
  - EOL:
    - Terminator → HOLD; cmd_valid=1 from the next cycle.
    - Other byte → DISCARD (an over-long argument is an error).
  - DISCARD: a terminator gives an err pulse → IDLE; all other bytes are dropped.
  - HOLD:
    - When cmd_valid & cmd_ready are both high, cmd_valid=0 on the next cycle and the FSM returns to IDLE.
    - An rx_done while in HOLD drops the byte and gives an ovr pulse on the next cycle.
    - rx_done and cmd_ready in the same cycle: the byte is dropped, ovr pulses, the handshake completes, and the FSM goes to IDLE.
- Latency: cmd_valid rises exactly one cycle after the cycle in which the terminator's rx_done is high.
- err and ovr are registered and appear in the cycle after the causing byte or event.
- Timeout:
  - The idle counter is active only in ADDR, DATA, EOL and DISCARD.
  - It clears on every consumed byte and increments on every cycle without rx_done.
  - The timeout fires when TIMEOUT_CYC consecutive cycles without rx_done follow the last consumed byte: err pulses in the next cycle and the FSM returns to IDLE.
  - If rx_done arrives in the same cycle the count would expire, the byte wins and the counter clears.
  - The counter is at least 32 bits wide.
- Reset mid-line or mid-HOLD: synchronous return to IDLE with all outputs at reset values. The pending command is lost, with no err or ovr pulse.

Test Plan:
1. Bytes "W1A5C\r": cmd_valid rises 1 cycle after the '\r' rx_done, with cmd_write=1, cmd_addr=0x1A, cmd_wdata=0x5C. Hold cmd_ready=0 for 10 cycles: fields stay stable. Then pulse cmd_ready: cmd_valid=0 the next cycle.
2. Continue with "\nr7f\r\n": the leading LF is ignored. Expect cmd_write=0, cmd_addr=0x7F, cmd_wdata=0x5C (retained). The trailing LF is ignored, with no err.
3. "W1G55\r": err pulses once, 1 cycle after the '\r'; cmd_valid never rises. Also "W12\r" (short line) gives err after the '\r'. Also "R123\r" (long line) gives err after the '\r'.
4. While cmd_valid=1 with cmd_ready=0, send 'R': ovr pulses 1 cycle and cmd_addr is unchanged. After cmd_ready, send "R05\r": a new command with cmd_addr=0x05.
5. TIMEOUT_CYC=50: send "W1" then silence. err pulses exactly once, 51 cycles after the '1' rx_done cycle, and busy falls with it. A subsequent "R10\r" decodes normally.
6. Send "W12" then rst=1 for 1 cycle: busy=0, cmd_valid=0 and all outputs at reset values. Then "34\r" gives no command (the '3' goes to DISCARD) and err after the '\r'.
